// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_W data bits, optional parity, 1-2 stop bits.
// A word is latched on the accept edge and sent with zero idle-to-start latency.
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              serial_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 2;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 16) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W must be 5..16");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_msb_first
        $error("uart_tx_param: MSB_FIRST must be 0 or 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_cnt_reg, baud_cnt_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic                parity_reg, parity_next;
    logic                serial_reg, serial_next;
    logic [DATA_W-1:0]   data_ordered;
    logic                bit_end;
    logic                accept;

    // Reorder once at load time so the shifter always emits bit 0 first.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
        if (MSB_FIRST != 0) begin : g_rev
            assign data_ordered[gi] = data[DATA_W-1-gi];
        end else begin : g_fwd
            assign data_ordered[gi] = data[gi];
        end
    end

    assign bit_end = (baud_cnt_reg == '0);
    assign accept  = valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            serial_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            serial_reg   <= serial_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg - BAUD_W'(1);
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        serial_next   = serial_reg;
        case (state_reg)
            S_IDLE: begin
                baud_cnt_next = '0;
                if (accept) begin
                    state_next    = S_START;
                    baud_cnt_next = BAUD_LAST;
                    bit_cnt_next  = '0;
                    shift_next    = data_ordered;
                    parity_next   = (^data) ^ (PARITY == 2);
                    serial_next   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next    = S_DATA;
                    baud_cnt_next = BAUD_LAST;
                    bit_cnt_next  = '0;
                    serial_next   = shift_reg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_next = BAUD_LAST;
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        if (PARITY != 0) begin
                            state_next  = S_PAR;
                            serial_next = parity_reg;
                        end else begin
                            state_next  = S_STOP;
                            serial_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                        shift_next   = shift_reg >> 1;
                        serial_next  = shift_reg[1];
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_next    = S_STOP;
                    baud_cnt_next = BAUD_LAST;
                    bit_cnt_next  = '0;
                    serial_next   = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        // Final stop-bit cycle doubles as the accept slot for back-to-back frames.
                        if (accept) begin
                            state_next    = S_START;
                            baud_cnt_next = BAUD_LAST;
                            bit_cnt_next  = '0;
                            shift_next    = data_ordered;
                            parity_next   = (^data) ^ (PARITY == 2);
                            serial_next   = 1'b0;
                        end else begin
                            state_next    = S_IDLE;
                            baud_cnt_next = '0;
                            bit_cnt_next  = '0;
                            serial_next   = 1'b1;
                        end
                    end else begin
                        baud_cnt_next = BAUD_LAST;
                        bit_cnt_next  = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next    = S_IDLE;
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                serial_next   = 1'b1;
            end
        endcase
    end

    always_comb begin
        tx_done    = (state_reg == S_STOP) && bit_end && (bit_cnt_reg == STOP_LAST);
        ready      = (state_reg == S_IDLE) || tx_done;
        busy       = (state_reg != S_IDLE);
        serial_out = serial_reg;
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter variants at CLKS_PER_BIT=4,
// frames checked cycle by cycle against hand-written bit strings.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] vld = 4'b0000;
    logic [7:0] dat0 = 8'h00, dat1 = 8'h00, dat2 = 8'h00, dat3 = 8'h00;
    logic [3:0] so, rdy, bsy, done;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .data(dat0), .valid(vld[0]), .ready(rdy[0]),
        .serial_out(so[0]), .busy(bsy[0]), .tx_done(done[0]));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst_n(rst_n), .data(dat1), .valid(vld[1]), .ready(rdy[1]),
        .serial_out(so[1]), .busy(bsy[1]), .tx_done(done[1]));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(0)) u2 (
        .clk(clk), .rst_n(rst_n), .data(dat2), .valid(vld[2]), .ready(rdy[2]),
        .serial_out(so[2]), .busy(bsy[2]), .tx_done(done[2]));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2), .MSB_FIRST(1)) u3 (
        .clk(clk), .rst_n(rst_n), .data(dat3), .valid(vld[3]), .ready(rdy[3]),
        .serial_out(so[3]), .busy(bsy[3]), .tx_done(done[3]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int u, input logic [7:0] d);
        case (u)
            0: dat0 = d;
            1: dat1 = d;
            2: dat2 = d;
            default: dat3 = d;
        endcase
    endtask

    // Present a word for exactly one accept edge; returns 1 time unit after that edge.
    task automatic send(input int u, input logic [7:0] d);
        @(negedge clk);
        set_data(u, d);
        vld[u] = 1'b1;
        @(posedge clk);
        #1 vld[u] = 1'b0;
    endtask

    // bits: one character per transmitted bit, start bit first; each bit lasts 4 cycles.
    task automatic check_frame(input int u, input string bits, input string name);
        int n = bits.len() * 4;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            chk($sformatf("%s serial c%0d", name, c), so[u], bits.getc((c - 1) / 4) == "1");
            chk($sformatf("%s tx_done c%0d", name, c), done[u], c == n);
            chk($sformatf("%s ready c%0d", name, c), rdy[u], c == n);
            chk($sformatf("%s busy c%0d", name, c), bsy[u], 1'b1);
        end
        $display("[TB] frame %s checked on u%0d (%0d cycles)", name, u, n);
    endtask

    task automatic check_idle(input int u, input string name);
        chk({name, " idle serial"}, so[u], 1'b1);
        chk({name, " idle ready"}, rdy[u], 1'b1);
        chk({name, " idle busy"}, bsy[u], 1'b0);
        chk({name, " idle tx_done"}, done[u], 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state on every variant
        #12;
        for (int u = 0; u < 4; u++) check_idle(u, $sformatf("reset u%0d", u));
        @(negedge clk);
        rst_n = 1'b1;

        // Defaults, 0x0B, LSB first, no parity, 1 stop
        send(0, 8'h0B);
        check_frame(0, "0110100001", "u0_0x0B");
        @(negedge clk);
        check_idle(0, "after u0_0x0B");

        // Even and odd parity on 0x0B (three ones -> even parity bit 1)
        send(1, 8'h0B);
        check_frame(1, "01101000011", "u1_even_0x0B");
        @(negedge clk);
        check_idle(1, "after u1");
        send(2, 8'h0B);
        check_frame(2, "01101000001", "u2_odd_0x0B");
        @(negedge clk);
        check_idle(2, "after u2");

        // MSB first, two stop bits, 0xA5
        send(3, 8'hA5);
        check_frame(3, "01010010111", "u3_msb_0xA5");
        @(negedge clk);
        check_idle(3, "after u3");

        // Back-to-back: VALID held, 0x55 then 0xAA
        @(negedge clk);
        dat0 = 8'h55;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 dat0 = 8'hAA;
        check_frame(0, "0101010101", "b2b_0x55");
        @(posedge clk);
        #1 vld[0] = 1'b0;
        check_frame(0, "0010101011", "b2b_0xAA");
        @(negedge clk);
        check_idle(0, "after b2b");

        // DATA changed and VALID re-asserted mid-frame: first word unaffected, second taken at TX_DONE
        send(0, 8'h0B);
        fork
            check_frame(0, "0110100001", "busy_0x0B");
            begin
                repeat (6) @(posedge clk);
                #1 dat0 = 8'hF0;
                vld[0] = 1'b1;
            end
        join
        @(posedge clk);
        #1 vld[0] = 1'b0;
        check_frame(0, "0000011111", "late_0xF0");
        @(negedge clk);
        check_idle(0, "after late");

        // Reset asserted in the middle of data bit 3
        send(0, 8'h0B);
        repeat (18) @(negedge clk);
        chk("pre-reset busy", bsy[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_idle(0, "async reset");
        repeat (3) begin
            @(negedge clk);
            chk("reset hold tx_done", done[0], 1'b0);
            chk("reset hold serial", so[0], 1'b1);
        end
        // First rising edge after release accepts the next word
        @(negedge clk);
        rst_n = 1'b1;
        dat0 = 8'h3C;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        check_frame(0, "0001111001", "post_reset_0x3C");
        @(negedge clk);
        check_idle(0, "final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the number of data bits per frame (legal 5..16).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the number of CLK cycles each serial bit is held (legal >= 2).
REQ-003 The block SHALL have parameter PARITY, default 0, selecting the parity bit: 0 = none, 1 = even, 2 = odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits (legal 1 or 2).
REQ-005 The block SHALL have parameter MSB_FIRST, default 0, selecting bit order: 0 = LSB first, 1 = MSB first.
REQ-006 CLK  input  1  single clock; all state changes on its rising edge.
REQ-007 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-008 DATA  input  DATA_W  parallel word to transmit; sampled only on the accept edge.
REQ-009 VALID  input  1  DATA is valid; held by the source until accepted.
REQ-010 READY  output  1  block can accept a word this cycle.
REQ-011 SERIAL_OUT  output  1  serial line; idle level 1.
REQ-012 BUSY  output  1  frame in progress.
REQ-013 TX_DONE  output  1  one-cycle pulse marking the final cycle of a frame.

Function
REQ-014 A word SHALL be accepted on a rising edge where VALID=1 and READY=1; DATA SHALL be latched on that edge, and later changes to DATA SHALL be ignored.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP, with transitions IDLE->START on accept, START->DATA, DATA->PAR (if PARITY!=0) or DATA->STOP, PAR->STOP, and STOP->IDLE or STOP->START.
REQ-016 SERIAL_OUT SHALL be registered and SHALL be 0 (start bit) starting immediately after the accept edge, giving zero cycles of idle-to-start latency.
REQ-017 Every bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a down-counter of width clog2(CLKS_PER_BIT) that reloads at each bit boundary.
REQ-018 Data bits SHALL be sent in the order bit0..bit(DATA_W-1) when MSB_FIRST=0, and in the reverse order otherwise.
REQ-019 The parity bit SHALL be the XOR of the latched word when PARITY=1, and its inversion when PARITY=2.
REQ-020 Stop bits SHALL be 1 and SHALL last STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 The frame length SHALL be exactly CLKS_PER_BIT*(1+DATA_W+(PARITY!=0)+STOP_BITS) cycles.
REQ-022 READY SHALL be 1 in IDLE and in the TX_DONE cycle, and 0 otherwise.
REQ-023 BUSY SHALL equal NOT READY, except that BUSY SHALL be 1 in the TX_DONE cycle.
REQ-024 TX_DONE SHALL pulse for one cycle, during the last cycle of the last stop bit.
REQ-025 Back-to-back: if VALID=1 on the TX_DONE edge, the next start bit SHALL follow with no idle cycle and the FSM SHALL go STOP->START.
REQ-026 VALID=0 on the TX_DONE edge SHALL return the FSM to IDLE with SERIAL_OUT=1.
REQ-027 VALID asserted while BUSY (outside the TX_DONE cycle) SHALL have no effect until READY rises.
REQ-028 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-029 While RST_N=0, the block SHALL asynchronously force FSM=IDLE, SERIAL_OUT=1, READY=1, BUSY=0, TX_DONE=0, bit counter=0 and baud counter=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame at once, with no TX_DONE and no partial stop bit.
REQ-031 On the first rising edge after RST_N deasserts, the block SHALL be able to accept a word.

Verification
REQ-032 Defaults with CLKS_PER_BIT=4, DATA=8'h0B pulsed for 1 cycle -> SERIAL_OUT = 0,1,1,0,1,0,0,0,0,1, each held 4 cycles; TX_DONE high in cycle 40 only; READY low for cycles 1-39.
REQ-033 PARITY=1, DATA=8'h0B -> parity bit 1 after bit7; frame 44 cycles. PARITY=2 -> parity bit 0.
REQ-034 STOP_BITS=2, MSB_FIRST=1, DATA=8'hA5 -> SERIAL_OUT = 0,1,0,1,0,0,1,0,1,1,1; 44 cycles.
REQ-035 VALID held high with 8'h55 then 8'hAA -> second start bit in the cycle after TX_DONE, with no idle-1 gap; both frames exact.
REQ-036 RST_N pulsed low in the middle of data bit 3 -> SERIAL_OUT=1 and READY=1 asynchronously, no TX_DONE; next accepted word is transmitted correctly.
REQ-037 DATA changed and VALID re-asserted while BUSY -> transmitted bits match the originally latched word, and the second word is accepted only at TX_DONE.
